arcade_input_ctrl: RTL and testbench
====================================

ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

Interface
REQ-001 SHALL have parameter NPLAYERS, default 2, number of player control words (1..4).
REQ-002 SHALL have parameter NDIP, default 8, number of 8-bit DIP banks (1..8).
REQ-003 SHALL have parameter DIP_INDEX, default 8'd254, ioctl index that carries DIP data.
REQ-004 SHALL have parameter COIN_MIN, default 600000, minimum coin pulse length in clk_sys cycles (50 ms at 12 MHz).
REQ-005 SHALL have parameter AF_DIV, default 400000, autofire half-period in clk_sys cycles.
REQ-006 SHALL have port clk_sys, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port ps2_key, input, 11, {toggle, pressed, ext, scancode}.
REQ-009 SHALL have port joystick, input, 16*NPLAYERS, per-player joystick words, player 0 in the LSBs.
REQ-010 SHALL have ports ioctl_wr (1), ioctl_index (8), ioctl_addr (25) and ioctl_dout (8), all inputs, the download bus.
REQ-011 SHALL have port autofire_en, input, NPLAYERS, per-player autofire enable.
REQ-012 SHALL have port ctrl, output, 8*NPLAYERS, per-player {coin,start,fire2,fire1,up,down,left,right}, active high.
REQ-013 SHALL have port dip, output, 8*NDIP, DIP banks, bank 0 in the LSBs.
REQ-014 SHALL have port dip_valid, output, 1, high once bank NDIP-1 has been written.

Function
REQ-015 SHALL register ps2_key[10] and detect a key event on any change of the toggle bit, one event per change.
REQ-016 On an event, SHALL set the matching key-held register to ps2_key[9]; unmapped codes SHALL be ignored.
REQ-017 Player 0 key map SHALL be: arrows (ext codes X75/X72/X6B/X74) for up/down/left/right; space (029) and ctrl (014) for fire1; alt (011) for fire2; 1 (016) and F1 (005) for start; 5 (02E) for coin.
REQ-018 Player 1 key map, when NPLAYERS>=2, SHALL be: R/F/D/G (02D/02B/023/034) for up/down/left/right; A (01C) for fire1; S (01B) for fire2; 2 (01E) and F2 (006) for start; 6 (036) for coin. Players 2..3 SHALL have no key map.
REQ-019 The raw input per player SHALL be the OR of key-held state and joystick bits [0]=right, [1]=left, [2]=down, [3]=up, [4]=fire1, [5]=fire2, [6]=start, [7]=coin.
REQ-020 Coin stretcher: on a raw coin rising edge, SHALL load a per-player counter with COIN_MIN-1; ctrl coin SHALL be high while raw coin is high or the counter is nonzero; the counter SHALL decrement to 0 and stop there.
REQ-021 A coin rising edge while the counter is nonzero SHALL reload the counter (retrigger).
REQ-022 Autofire: a shared divider SHALL toggle phase every AF_DIV cycles; when autofire_en[p] is set, ctrl fire1 SHALL be raw fire1 AND phase, otherwise raw fire1.
REQ-023 All ctrl outputs SHALL be registered, with latency of one clk_sys cycle from raw input to ctrl (coin rise included).
REQ-024 A DIP write SHALL occur when ioctl_wr is high, ioctl_index==DIP_INDEX and ioctl_addr<NDIP; dip[8*a+:8] SHALL take ioctl_dout on the next edge.
REQ-025 Writes with ioctl_addr>=NDIP or a different index SHALL leave dip and dip_valid unchanged.
REQ-026 dip_valid SHALL rise on the edge that writes bank NDIP-1 and SHALL stay high until RESET.
REQ-027 Simultaneous key event and joystick change SHALL both take effect; the OR is used.

Reset
REQ-028 While RESET is high: all key-held registers, coin counters, divider and phase 0; ctrl all 0; dip all 8'hFF; dip_valid 0.
REQ-029 Reset mid-coin-pulse SHALL clear the counter immediately; after release, coin SHALL follow raw input only.
REQ-030 The toggle register SHALL reset to 0, so a ps2_key[10]=1 present at release SHALL produce one event.

Verification
REQ-031 Toggle ps2_key with {1,1,0x029} -> ctrl[4]=1 one cycle later; toggle with {0,0x029} -> ctrl[4]=0.
REQ-032 joystick[7] high for 1 cycle, COIN_MIN=100 -> ctrl[7] high for exactly 100 cycles; second pulse at cycle 50 -> high until cycle 150.
REQ-033 autofire_en=01, AF_DIV=10, joystick[4] held -> ctrl[4] square wave of 10 cycles high and 10 low; ctrl[12] follows its raw input unmodulated.
REQ-034 ioctl writes index 254, addr 0..7, data 0x10..0x17 -> dip=0x1716151413121110, dip_valid rises on the addr-7 write; addr 8 and index 253 writes -> no change.
REQ-035 RESET asserted mid-coin and mid-key-hold -> ctrl=0, dip=all 0xFF and dip_valid=0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: merges PS/2 keys and joysticks into registered per-player
// control words (coin stretch, autofire) and captures DIP banks from the download bus.
module arcade_input_ctrl #(
   parameter int         NPLAYERS  = 2,
   parameter int         NDIP      = 8,
   parameter logic [7:0] DIP_INDEX = 8'd254,
   parameter int         COIN_MIN  = 600000,
   parameter int         AF_DIV    = 400000
) (
   input  logic                   clk_sys,
   input  logic                   RESET,
   input  logic [10:0]            ps2_key,
   input  logic [16*NPLAYERS-1:0] joystick,
   input  logic                   ioctl_wr,
   input  logic [7:0]             ioctl_index,
   input  logic [24:0]            ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   input  logic [NPLAYERS-1:0]    autofire_en,
   output logic [8*NPLAYERS-1:0]  ctrl,
   output logic [8*NDIP-1:0]      dip,
   output logic                   dip_valid
);

   localparam int CW = (COIN_MIN > 1) ? $clog2(COIN_MIN) : 1;
   localparam int DW = (AF_DIV > 1) ? $clog2(AF_DIV) : 1;

   localparam int B_RIGHT = 0;
   localparam int B_LEFT  = 1;
   localparam int B_DOWN  = 2;
   localparam int B_UP    = 3;
   localparam int B_FIRE1 = 4;
   localparam int B_FIRE2 = 5;
   localparam int B_START = 6;
   localparam int B_COIN  = 7;

   // One held register per physical key, so two keys sharing a function
   // (space/ctrl, 1/F1) release independently.
   localparam int K_R0  = 0;
   localparam int K_L0  = 1;
   localparam int K_D0  = 2;
   localparam int K_U0  = 3;
   localparam int K_SPC = 4;
   localparam int K_CTL = 5;
   localparam int K_ALT = 6;
   localparam int K_1   = 7;
   localparam int K_F1  = 8;
   localparam int K_5   = 9;
   localparam int K_R1  = 10;
   localparam int K_L1  = 11;
   localparam int K_D1  = 12;
   localparam int K_U1  = 13;
   localparam int K_A   = 14;
   localparam int K_S   = 15;
   localparam int K_2   = 16;
   localparam int K_F2  = 17;
   localparam int K_6   = 18;
   localparam int NKEY  = 19;

   logic                  tog_q;
   logic                  key_ev;
   logic [8:0]            key_code;
   logic [NKEY-1:0]       key_q, key_d;

   logic [CW-1:0]         cnt_q [NPLAYERS];
   logic [CW-1:0]         cnt_d [NPLAYERS];
   logic [NPLAYERS-1:0]   coin_prev_q, coin_prev_d;

   logic [DW-1:0]         div_q, div_d;
   logic                  phase_q, phase_d;

   logic [8*NPLAYERS-1:0] ctrl_q, ctrl_d;
   logic                  unused_hi;

   logic [8*NDIP-1:0]     dip_q, dip_d;
   logic                  dip_valid_q, dip_valid_d;
   logic                  dip_wr;

   assign key_ev   = ps2_key[10] ^ tog_q;
   assign key_code = {ps2_key[8], ps2_key[7:0]};

   always_comb begin
      key_d = key_q;
      if (key_ev) begin
         case (key_code)
            9'h175: key_d[K_U0]  = ps2_key[9];
            9'h172: key_d[K_D0]  = ps2_key[9];
            9'h16B: key_d[K_L0]  = ps2_key[9];
            9'h174: key_d[K_R0]  = ps2_key[9];
            9'h029: key_d[K_SPC] = ps2_key[9];
            9'h014: key_d[K_CTL] = ps2_key[9];
            9'h011: key_d[K_ALT] = ps2_key[9];
            9'h016: key_d[K_1]   = ps2_key[9];
            9'h005: key_d[K_F1]  = ps2_key[9];
            9'h02E: key_d[K_5]   = ps2_key[9];
            9'h02D: key_d[K_U1]  = ps2_key[9];
            9'h02B: key_d[K_D1]  = ps2_key[9];
            9'h023: key_d[K_L1]  = ps2_key[9];
            9'h034: key_d[K_R1]  = ps2_key[9];
            9'h01C: key_d[K_A]   = ps2_key[9];
            9'h01B: key_d[K_S]   = ps2_key[9];
            9'h01E: key_d[K_2]   = ps2_key[9];
            9'h006: key_d[K_F2]  = ps2_key[9];
            9'h036: key_d[K_6]   = ps2_key[9];
            default: ;
         endcase
      end
   end

   always_comb begin
      div_d   = div_q + DW'(1);
      phase_d = phase_q;
      if (div_q == DW'(AF_DIV - 1)) begin
         div_d   = '0;
         phase_d = ~phase_q;
      end
   end

   // Raw input uses the next key state so a key event reaches ctrl in one edge.
   always_comb begin
      ctrl_d      = '0;
      coin_prev_d = coin_prev_q;
      unused_hi   = 1'b0;
      for (int p = 0; p < NPLAYERS; p++) begin
         logic [7:0] kb;
         logic [7:0] raw;
         logic       rise;
         kb = 8'h00;
         if (p == 0) begin
            kb = {key_d[K_5], key_d[K_1] | key_d[K_F1], key_d[K_ALT],
                  key_d[K_SPC] | key_d[K_CTL],
                  key_d[K_U0], key_d[K_D0], key_d[K_L0], key_d[K_R0]};
         end else if (p == 1) begin
            kb = {key_d[K_6], key_d[K_2] | key_d[K_F2], key_d[K_S], key_d[K_A],
                  key_d[K_U1], key_d[K_D1], key_d[K_L1], key_d[K_R1]};
         end
         raw       = kb | joystick[16*p +: 8];
         unused_hi = unused_hi ^ (^joystick[16*p+8 +: 8]);
         rise      = raw[B_COIN] & ~coin_prev_q[p];

         if (rise) begin
            cnt_d[p] = CW'(COIN_MIN - 1);
         end else if (cnt_q[p] != '0) begin
            cnt_d[p] = cnt_q[p] - CW'(1);
         end else begin
            cnt_d[p] = '0;
         end
         coin_prev_d[p] = raw[B_COIN];

         ctrl_d[8*p +: 8]        = raw;
         ctrl_d[8*p + B_COIN]    = raw[B_COIN] | (cnt_q[p] != '0);
         ctrl_d[8*p + B_FIRE1]   = raw[B_FIRE1] & (phase_q | ~autofire_en[p]);
      end
   end

   always_comb begin
      dip_d       = dip_q;
      dip_valid_d = dip_valid_q;
      dip_wr      = ioctl_wr && (ioctl_index == DIP_INDEX);
      for (int b = 0; b < NDIP; b++) begin
         if (dip_wr && (ioctl_addr == 25'(b))) begin
            dip_d[8*b +: 8] = ioctl_dout;
            if (b == NDIP - 1) dip_valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_sys or posedge RESET) begin
      if (RESET) begin
         tog_q       <= 1'b0;
         key_q       <= '0;
         coin_prev_q <= '0;
         for (int p = 0; p < NPLAYERS; p++) cnt_q[p] <= '0;
         div_q       <= '0;
         phase_q     <= 1'b0;
         ctrl_q      <= '0;
         dip_q       <= '1;
         dip_valid_q <= 1'b0;
      end else begin
         tog_q       <= ps2_key[10];
         key_q       <= key_d;
         coin_prev_q <= coin_prev_d;
         for (int p = 0; p < NPLAYERS; p++) cnt_q[p] <= cnt_d[p];
         div_q       <= div_d;
         phase_q     <= phase_d;
         ctrl_q      <= ctrl_d;
         dip_q       <= dip_d;
         dip_valid_q <= dip_valid_d;
      end
   end

   assign ctrl      = ctrl_q;
   assign dip       = dip_q;
   assign dip_valid = dip_valid_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl: directed scenarios plus random stimulus, all
// compared against a time/table based reference model.
module tb_arcade_input_ctrl;

   localparam int NP   = 2;
   localparam int ND   = 8;
   localparam int CMIN = 100;
   localparam int AFD  = 10;

   logic          clk_sys = 1'b0;
   logic          RESET;
   logic [10:0]   ps2_key;
   logic [31:0]   joystick;
   logic          ioctl_wr;
   logic [7:0]    ioctl_index;
   logic [24:0]   ioctl_addr;
   logic [7:0]    ioctl_dout;
   logic [1:0]    autofire_en;
   logic [15:0]   ctrl;
   logic [63:0]   dip;
   logic          dip_valid;

   always #5 clk_sys = ~clk_sys;

   arcade_input_ctrl #(
      .NPLAYERS (NP),
      .NDIP     (ND),
      .DIP_INDEX(8'd254),
      .COIN_MIN (CMIN),
      .AF_DIV   (AFD)
   ) dut (
      .clk_sys    (clk_sys),
      .RESET      (RESET),
      .ps2_key    (ps2_key),
      .joystick   (joystick),
      .ioctl_wr   (ioctl_wr),
      .ioctl_index(ioctl_index),
      .ioctl_addr (ioctl_addr),
      .ioctl_dout (ioctl_dout),
      .autofire_en(autofire_en),
      .ctrl       (ctrl),
      .dip        (dip),
      .dip_valid  (dip_valid)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Key map table: player, {ext,code}, ctrl bit
   int         km_pl   [19] = '{0,0,0,0,0,0,0,0,0,0, 1,1,1,1,1,1,1,1,1};
   logic [8:0] km_code [19] = '{9'h175,9'h172,9'h16B,9'h174,9'h029,9'h014,9'h011,9'h016,9'h005,9'h02E,
                                9'h02D,9'h02B,9'h023,9'h034,9'h01C,9'h01B,9'h01E,9'h006,9'h036};
   int         km_bit  [19] = '{3,2,1,0,4,4,5,6,6,7, 3,2,1,0,4,5,6,6,7};
   logic [8:0] km_extra [4] = '{9'h075, 9'h114, 9'h044, 9'h12D};

   bit          held [512];
   bit          tog_m;
   longint      n_edge;
   longint      last_rise [NP];
   bit          prev_coin [NP];
   logic [7:0]  dip_m [ND];
   bit          valid_m;
   logic [15:0] exp_ctrl;

   function automatic logic [7:0] raw_of(int p);
      logic [7:0] r;
      r = joystick[16*p +: 8];
      for (int i = 0; i < 19; i++)
         if (km_pl[i] == p && held[km_code[i]]) r[km_bit[i]] = 1'b1;
      return r;
   endfunction

   function automatic logic [63:0] dip_pack();
      logic [63:0] r;
      for (int b = 0; b < ND; b++) r[8*b +: 8] = dip_m[b];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 512; i++) held[i] = 1'b0;
      tog_m = 1'b0;
      n_edge = 0;
      for (int p = 0; p < NP; p++) begin
         last_rise[p] = -1000000;
         prev_coin[p] = 1'b0;
      end
      for (int b = 0; b < ND; b++) dip_m[b] = 8'hFF;
      valid_m = 1'b0;
   endtask

   // Expected outputs after the coming rising edge, from the inputs now applied.
   task automatic model_edge();
      logic [7:0] r;
      if (ps2_key[10] != tog_m) begin
         tog_m = ps2_key[10];
         held[{ps2_key[8], ps2_key[7:0]}] = ps2_key[9];
      end
      for (int p = 0; p < NP; p++) begin
         r = raw_of(p);
         if (r[7] && !prev_coin[p]) last_rise[p] = n_edge;
         prev_coin[p] = r[7];
         exp_ctrl[8*p +: 8] = r;
         exp_ctrl[8*p + 7]  = r[7] || ((n_edge - last_rise[p]) < CMIN);
         if (autofire_en[p]) exp_ctrl[8*p + 4] = r[4] && (((n_edge / AFD) % 2) == 1);
      end
      if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < ND) begin
         dip_m[int'(ioctl_addr)] = ioctl_dout;
         if (ioctl_addr == ND - 1) valid_m = 1'b1;
      end
      n_edge++;
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clk_sys);
      #1;
      check_val({tag, ".ctrl"}, {48'd0, ctrl}, {48'd0, exp_ctrl});
      check_val({tag, ".dip"}, dip, dip_pack());
      check_val({tag, ".dip_valid"}, {63'd0, dip_valid}, {63'd0, valid_m});
   endtask

   task automatic do_reset(input string tag);
      RESET = 1'b1;
      #1;
      check_val({tag, ".ctrl_async"}, {48'd0, ctrl}, 64'd0);
      check_val({tag, ".dip_async"}, dip, {64{1'b1}});
      check_val({tag, ".valid_async"}, {63'd0, dip_valid}, 64'd0);
      @(posedge clk_sys);
      @(posedge clk_sys);
      #1;
      model_reset();
      RESET = 1'b0;
   endtask

   task automatic coin_run(input bit retrig, input int exp_len, input string tag);
      int hi;
      hi = 0;
      for (int i = 0; i < 170; i++) begin
         joystick[7] = (i == 0) || (retrig && i == 50);
         step(tag);
         hi += int'(ctrl[7]);
      end
      joystick[7] = 1'b0;
      check_val({tag, ".len"}, 64'(hi), 64'(exp_len));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int         hi4, hi12, idx;
      logic [8:0] code;

      RESET = 1'b0;
      ps2_key = '0;
      joystick = '0;
      ioctl_wr = 1'b0;
      ioctl_index = 8'd0;
      ioctl_addr = '0;
      ioctl_dout = 8'd0;
      autofire_en = 2'b00;
      #3;
      do_reset("rst0");

      // key press/release on space
      ps2_key = {1'b1, 1'b1, 1'b0, 8'h29};
      step("space_dn");
      check_val("space_press", {63'd0, ctrl[4]}, 64'd1);
      step("space_hold");
      step("space_hold");
      ps2_key = {1'b0, 1'b0, 1'b0, 8'h29};
      step("space_up");
      check_val("space_release", {63'd0, ctrl[4]}, 64'd0);

      coin_run(1'b0, 100, "coin_single");
      coin_run(1'b1, 150, "coin_retrig");

      // autofire on player 0 only
      autofire_en = 2'b01;
      joystick[4] = 1'b1;
      joystick[20] = 1'b1;
      for (int i = 0; i < 20; i++) step("af_warm");
      hi4 = 0;
      hi12 = 0;
      for (int i = 0; i < 40; i++) begin
         step("af");
         hi4 += int'(ctrl[4]);
         hi12 += int'(ctrl[12]);
      end
      check_val("af_p0_duty", 64'(hi4), 64'd20);
      check_val("af_p1_steady", 64'(hi12), 64'd40);
      joystick = '0;
      autofire_en = 2'b00;
      step("af_off");

      // DIP download
      ioctl_wr = 1'b1;
      ioctl_index = 8'd254;
      for (int a = 0; a < ND; a++) begin
         ioctl_addr = 25'(a);
         ioctl_dout = 8'h10 + 8'(a);
         step("dip_wr");
         if (a == ND - 2) check_val("dip_valid_early", {63'd0, dip_valid}, 64'd0);
      end
      check_val("dip_valid_rise", {63'd0, dip_valid}, 64'd1);
      check_val("dip_value", dip, 64'h1716151413121110);
      ioctl_addr = 25'd8;
      ioctl_dout = 8'hAA;
      step("dip_oob");
      ioctl_index = 8'd253;
      ioctl_addr = 25'd0;
      step("dip_badidx");
      check_val("dip_unchanged", dip, 64'h1716151413121110);
      ioctl_wr = 1'b0;

      // reset while a coin is stretching and a key is held
      ps2_key = {1'b1, 1'b1, 1'b0, 8'h29};
      joystick[7] = 1'b1;
      step("mid_a");
      joystick[7] = 1'b0;
      for (int i = 0; i < 5; i++) step("mid_b");
      RESET = 1'b1;
      ps2_key = {1'b1, 1'b1, 1'b0, 8'h11};
      do_reset("rst_mid");
      step("post_rst");
      check_val("tog_at_release", {63'd0, ctrl[5]}, 64'd1);
      check_val("space_cleared", {63'd0, ctrl[4]}, 64'd0);
      check_val("coin_cleared", {63'd0, ctrl[7]}, 64'd0);
      step("post_rst2");

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            idx = $urandom_range(0, 22);
            code = (idx < 19) ? km_code[idx] : km_extra[idx-19];
            ps2_key = {~ps2_key[10], 1'($urandom), code[8], code[7:0]};
         end else if ($urandom_range(0, 3) == 0) begin
            ps2_key[9:0] = 10'($urandom);
         end
         joystick = joystick ^ ($urandom & $urandom & $urandom);
         if ($urandom_range(0, 49) == 0) autofire_en = 2'($urandom);
         ioctl_wr = ($urandom_range(0, 7) == 0);
         ioctl_index = ($urandom_range(0, 1) == 0) ? 8'd254 : 8'd253;
         ioctl_addr = 25'($urandom_range(0, 10));
         ioctl_dout = 8'($urandom);
         if ($urandom_range(0, 399) == 0) do_reset("rst_rand");
         step("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
